// File: rtl/csr_unit.sv
// Machine-mode CSR block: scratch registers plus cycle/instret counters.
// Each accepted operation returns the old CSR value one cycle later.
module csr_unit #(
    parameter int unsigned NUM_SCRATCH   = 4,
    parameter int unsigned CNT_WIDTH     = 64,
    parameter logic [31:0] RESET_SCRATCH = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    input  logic        retire,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        illegal
);

    localparam int unsigned HI_W = CNT_WIDTH - 32;

    localparam logic [11:0] ADDR_SCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRH   = 12'hC82;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [31:0]          scratch_q [NUM_SCRATCH];
    logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
    logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 illegal_q, illegal_d;

    logic [NUM_SCRATCH-1:0] scr_hit;
    logic        mapped;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        eff_write;
    logic        op_illegal;
    logic        do_write;
    logic        sel_cyc_lo, sel_cyc_hi, sel_ret_lo, sel_ret_hi;

    // Address decode and old-value mux.
    always_comb begin
        scr_hit    = '0;
        mapped     = 1'b0;
        old_val    = 32'h0;
        sel_cyc_lo = 1'b0;
        sel_cyc_hi = 1'b0;
        sel_ret_lo = 1'b0;
        sel_ret_hi = 1'b0;
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (addr == ADDR_SCRATCH + 12'(i)) begin
                scr_hit[i] = 1'b1;
                mapped     = 1'b1;
                old_val    = scratch_q[i];
            end
        end
        case (addr)
            ADDR_MCYCLE, ADDR_CYCLE: begin
                mapped     = 1'b1;
                old_val    = mcycle_q[31:0];
                sel_cyc_lo = (addr == ADDR_MCYCLE);
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                mapped     = 1'b1;
                old_val    = 32'(mcycle_q[CNT_WIDTH-1:32]);
                sel_cyc_hi = (addr == ADDR_MCYCLEH);
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                mapped     = 1'b1;
                old_val    = minstret_q[31:0];
                sel_ret_lo = (addr == ADDR_MINSTRET);
            end
            ADDR_MINSTRH, ADDR_INSTRH: begin
                mapped     = 1'b1;
                old_val    = 32'(minstret_q[CNT_WIDTH-1:32]);
                sel_ret_hi = (addr == ADDR_MINSTRH);
            end
            default: ;
        endcase
    end

    // RS/RC with a zero mask are pure reads; only real writes can be refused as read-only.
    always_comb begin
        new_val   = old_val;
        eff_write = 1'b0;
        case (op)
            OP_RW: begin
                new_val   = wdata;
                eff_write = 1'b1;
            end
            OP_RS: begin
                new_val   = old_val | wdata;
                eff_write = (wdata != 32'h0);
            end
            OP_RC: begin
                new_val   = old_val & ~wdata;
                eff_write = (wdata != 32'h0);
            end
            OP_READ: ;
            default: ;
        endcase
        op_illegal = !mapped || (eff_write && (addr[11:10] == 2'b11));
        do_write   = op_valid && eff_write && !op_illegal;
    end

    // A software write to either half wins over that cycle's increment.
    always_comb begin
        mcycle_d   = mcycle_q + CNT_WIDTH'(1);
        minstret_d = retire ? (minstret_q + CNT_WIDTH'(1)) : minstret_q;
        if (do_write && sel_cyc_lo) mcycle_d = {mcycle_q[CNT_WIDTH-1:32], new_val};
        if (do_write && sel_cyc_hi) mcycle_d = {new_val[HI_W-1:0], mcycle_q[31:0]};
        if (do_write && sel_ret_lo) minstret_d = {minstret_q[CNT_WIDTH-1:32], new_val};
        if (do_write && sel_ret_hi) minstret_d = {new_val[HI_W-1:0], minstret_q[31:0]};
    end

    // Response registers hold their last value between operations.
    always_comb begin
        rvalid_d  = op_valid;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        if (op_valid) begin
            rdata_d   = op_illegal ? 32'h0 : old_val;
            illegal_d = op_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            illegal_q  <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= RESET_SCRATCH;
        end else begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (do_write && scr_hit[i]) scratch_q[i] <= new_val;
            end
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations queued at issue, checked when rvalid returns.
module tb_csr_unit;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0000;
    localparam int unsigned NSCR    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        retire;
    logic [31:0] rdata;
    logic        rvalid;
    logic        illegal;

    csr_unit #(
        .NUM_SCRATCH  (NSCR),
        .CNT_WIDTH    (64),
        .RESET_SCRATCH(RST_VAL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_valid(op_valid),
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .retire  (retire),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ill;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned pcnt    = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one op in the current cycle and queue its expected response.
    task automatic drive(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                         input string tag, input logic [31:0] lo, input logic [31:0] hi,
                         input logic ill);
        exp_t e;
        op_valid = 1'b1;
        op       = o;
        addr     = a;
        wdata    = d;
        e.tag = tag; e.lo = lo; e.hi = hi; e.ill = ill; e.cyc = pcnt;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                         input string tag, input logic [31:0] lo, input logic [31:0] hi,
                         input logic ill);
        @(negedge clk);
        drive(o, a, d, tag, lo, hi, ill);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    // Response checker: every rvalid must match the oldest outstanding op, one cycle later.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst_n === 1'b1 && rvalid !== 1'b0) begin
            n_total++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL stale_rvalid observed rvalid=%b expected no response", rvalid);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                assert (e.cyc + 1 == pcnt) n_pass++;
                else $error("FAIL %s_latency observed=%0d expected=%0d", e.tag, pcnt - e.cyc, 1);
                n_total++;
                assert (illegal === e.ill) n_pass++;
                else $error("FAIL %s_illegal observed=%b expected=%b", e.tag, illegal, e.ill);
                ok = (rdata >= e.lo) && (rdata <= e.hi);
                n_total++;
                assert (ok === 1'b1) n_pass++;
                else $error("FAIL %s_rdata observed=%h expected=%h..%h", e.tag, rdata, e.lo, e.hi);
            end
        end
    end

    initial begin
        logic [31:0] v340;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 2'b00;
        addr     = 12'h0;
        wdata    = 32'h0;
        retire   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_rdata",   rdata,          32'h0);
        check_now("reset_rvalid",  32'(rvalid),    32'h0);
        check_now("reset_illegal", 32'(illegal),   32'h0);
        #1 rst_n = 1'b1;

        // First read after reset release sees an almost-zero cycle count.
        issue(2'b00, 12'hC00, 32'h0, "cycle_first", 32'd0, 32'd1, 1'b0);
        issue(2'b00, 12'h340, 32'h0, "scr_reset", RST_VAL, RST_VAL, 1'b0);

        // Back-to-back RW/RS/RC on one scratch register.
        v340 = (32'hDEADBEEF | 32'h0000000F) & ~32'hF0000000;
        issue(2'b01, 12'h340, 32'hDEADBEEF, "rw340", RST_VAL, RST_VAL, 1'b0);
        issue(2'b10, 12'h340, 32'h0000000F, "rs340", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        issue(2'b11, 12'h340, 32'hF0000000, "rc340", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        issue(2'b00, 12'h340, 32'h0, "rd340", v340, v340, 1'b0);
        issue(2'b01, 12'h341, 32'h11111111, "rw341", RST_VAL, RST_VAL, 1'b0);
        issue(2'b01, 12'h342, 32'h22222222, "rw342", RST_VAL, RST_VAL, 1'b0);
        issue(2'b01, 12'h343, 32'h33333333, "rw343", RST_VAL, RST_VAL, 1'b0);

        // Unmapped addresses are refused with zero data and no write.
        issue(2'b01, 12'h340 + 12'(NSCR), 32'h0BAD0BAD, "rw_past_scr", 32'h0, 32'h0, 1'b1);
        issue(2'b01, 12'h7FF, 32'h0BAD0BAD, "rw_7ff", 32'h0, 32'h0, 1'b1);
        issue(2'b10, 12'h345, 32'h0, "rd_unmapped", 32'h0, 32'h0, 1'b1);
        issue(2'b00, 12'h340, 32'h0, "chk340", v340, v340, 1'b0);
        issue(2'b00, 12'h341, 32'h0, "chk341", 32'h11111111, 32'h11111111, 1'b0);
        issue(2'b00, 12'h342, 32'h0, "chk342", 32'h22222222, 32'h22222222, 1'b0);
        issue(2'b00, 12'h343, 32'h0, "chk343", 32'h33333333, 32'h33333333, 1'b0);
        issue(2'b11, 12'h341, 32'h0, "rc_zero", 32'h11111111, 32'h11111111, 1'b0);
        issue(2'b00, 12'h341, 32'h0, "rc_zero_nowrite", 32'h11111111, 32'h11111111, 1'b0);

        // Cycle counter: write, read-only refusal, carry into the high half.
        issue(2'b01, 12'hB00, 32'd1000, "mcycle_wr", 32'd1, 32'd200, 1'b0);
        issue(2'b01, 12'hC00, 32'd5, "cycle_ro_wr", 32'h0, 32'h0, 1'b1);
        issue(2'b10, 12'hC00, 32'h0, "cycle_ro_rd", 32'd1001, 32'd1001, 1'b0);
        issue(2'b01, 12'hB00, 32'hFFFFFFFF, "mcycle_ff", 32'd1002, 32'd1002, 1'b0);
        idle(2);
        issue(2'b00, 12'hB80, 32'h0, "mcycleh_carry", 32'd1, 32'd1, 1'b0);
        issue(2'b00, 12'hB00, 32'h0, "mcycle_after", 32'd2, 32'd2, 1'b0);
        issue(2'b00, 12'hC80, 32'h0, "cycleh_shadow", 32'd1, 32'd1, 1'b0);
        issue(2'b01, 12'hB80, 32'd7, "mcycleh_wr", 32'd1, 32'd1, 1'b0);
        issue(2'b00, 12'hB00, 32'h0, "mcycle_suppr", 32'd4, 32'd4, 1'b0);
        issue(2'b00, 12'hB80, 32'h0, "mcycleh_rd", 32'd7, 32'd7, 1'b0);

        // Instret: ten retires with a coincident write on the fifth.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            retire = 1'b1;
            if (c == 5) drive(2'b01, 12'hB02, 32'd100, "minstret_wr", 32'd4, 32'd4, 1'b0);
            else op_valid = 1'b0;
        end
        @(negedge clk);
        retire = 1'b0;
        drive(2'b00, 12'hB02, 32'h0, "minstret_end", 32'd105, 32'd105, 1'b0);
        issue(2'b00, 12'hB82, 32'h0, "minstreth", 32'd0, 32'd0, 1'b0);
        issue(2'b00, 12'hC02, 32'h0, "instret_shadow", 32'd105, 32'd105, 1'b0);
        issue(2'b01, 12'hB82, 32'd3, "minstreth_wr", 32'd0, 32'd0, 1'b0);
        issue(2'b00, 12'hC82, 32'h0, "instreth_shadow", 32'd3, 32'd3, 1'b0);

        // Reset mid-stream: outputs clear at once and the in-flight op is lost.
        issue(2'b01, 12'h341, 32'h00001234, "rw341_pre", 32'h11111111, 32'h11111111, 1'b0);
        issue(2'b00, 12'h341, 32'h0, "rd341_pre", 32'h00001234, 32'h00001234, 1'b0);
        @(negedge clk);
        op_valid = 1'b1;
        op       = 2'b01;
        addr     = 12'h341;
        wdata    = 32'h00005555;
        #2 rst_n = 1'b0;
        #1;
        check_now("async_rst_rdata",   rdata,        32'h0);
        check_now("async_rst_rvalid",  32'(rvalid),  32'h0);
        check_now("async_rst_illegal", 32'(illegal), 32'h0);
        op_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        issue(2'b00, 12'h341, 32'h0, "post_rst341", RST_VAL, RST_VAL, 1'b0);
        issue(2'b00, 12'h340, 32'h0, "post_rst340", RST_VAL, RST_VAL, 1'b0);
        issue(2'b00, 12'hB02, 32'h0, "post_rst_instret", 32'h0, 32'h0, 1'b0);
        idle(4);

        n_total++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL drain observed=%0d pending expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop so a stalled run still ends with a report.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
